my_serializer: RTL and testbench

//  Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready

---
 rtl/my_serializer.sv | 197 +++++++++++++++++++
 tb/tb_my_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/my_serializer.sv
// -----------------------------------------------------------------------------
// my_serializer
//
// Parallel-in, serial-out transmitter. A WIDTH-bit word is taken over a
// valid/ready load handshake and driven out one bit per clk on sout. sout_valid
// marks every frame bit and frame_start marks the first bit of each frame, so a
// downstream deserializer knows when to sample. When the next word is offered
// during the final beat of a frame, frames run back to back with no idle cycles.
//
// Parameters
//   WIDTH      data bits per frame (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] is sent first, 0: din[0] is sent first
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   din          in   parallel word, captured only on an accepted load
//   load_valid   in   sender has a word on din
//   load_ready   out  a word on din is accepted this cycle
//   sout         out  serial data bit (0 while idle)
//   sout_valid   out  sout carries a frame bit this cycle
//   frame_start  out  first bit of a frame
//   busy         out  a frame is in progress
//
// Build option
//   MY_SERIALIZER_PARITY_EN  when defined, each frame ends with an extra beat
//                            that carries the even-parity bit of the word
//                            (^din). The frame is then WIDTH+1 clks long.
//
// State table
//   state  | meaning
//   IDLE   | no frame in flight; sout=0, ready for a new word
//   SHIFT  | sending data bit number cnt_q of the current frame
//   PARITY | sending the parity bit (parity build only)
// -----------------------------------------------------------------------------
module my_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef MY_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] sreg_shifted;
`ifdef MY_SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

    // Ready is offered in the final beat of a frame as well as in IDLE so the
    // next word can be captured on the same edge the current frame ends.
`ifdef MY_SERIALIZER_PARITY_EN
    assign load_ready = (state_q == IDLE) || (state_q == PARITY);
`else
    assign load_ready = (state_q == IDLE) || last_bit;
`endif

    assign accept = load_valid && load_ready;

    // The bit on sout is always at the outgoing end of the shift register;
    // the register moves toward that end by one place per beat.
    always_comb begin
        if (MSB_FIRST != 0) begin
            sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
`ifdef MY_SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
`ifdef MY_SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
`ifdef MY_SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = SHIFT;
                    sreg_d   = din;
                    cnt_d    = '0;
`ifdef MY_SERIALIZER_PARITY_EN
                    parity_d = ^din;
`endif
                end
            end

            SHIFT: begin
                sreg_d = sreg_shifted;
                if (cnt_q == LAST) begin
                    cnt_d = '0;
`ifdef MY_SERIALIZER_PARITY_EN
                    state_d = PARITY;
`else
                    if (accept) begin
                        state_d = SHIFT;
                        sreg_d  = din;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef MY_SERIALIZER_PARITY_EN
            PARITY: begin
                cnt_d = '0;
                if (accept) begin
                    state_d  = SHIFT;
                    sreg_d   = din;
                    parity_d = ^din;
                end else begin
                    state_d = IDLE;
                end
            end
`endif

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sout = 1'b0;
        case (state_q)
            SHIFT: begin
                if (MSB_FIRST != 0) begin
                    sout = sreg_q[WIDTH-1];
                end else begin
                    sout = sreg_q[0];
                end
            end
`ifdef MY_SERIALIZER_PARITY_EN
            PARITY: sout = parity_q;
`endif
            default: sout = 1'b0;
        endcase
    end

    assign sout_valid  = (state_q != IDLE);
    assign busy        = (state_q != IDLE);
    assign frame_start = (state_q == SHIFT) && (cnt_q == '0);

endmodule

// File: tb/tb_my_serializer.sv
module tb_my_serializer;

    typedef struct packed {
        logic sout;
        logic fs;
        logic rdy;
    } exp_t;

    logic       clk;
    logic       reset;

    logic [7:0] d0_din, d1_din;
    logic       d0_lv, d1_lv;
    logic       d0_ready, d0_sout, d0_valid, d0_fs, d0_busy;
    logic       d1_ready, d1_sout, d1_valid, d1_fs, d1_busy;

    exp_t       q0[$];
    exp_t       q1[$];

    int         total;
    int         bad;

    my_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk         (clk),
        .reset       (reset),
        .din         (d0_din),
        .load_valid  (d0_lv),
        .load_ready  (d0_ready),
        .sout        (d0_sout),
        .sout_valid  (d0_valid),
        .frame_start (d0_fs),
        .busy        (d0_busy)
    );

    my_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk         (clk),
        .reset       (reset),
        .din         (d1_din),
        .load_valid  (d1_lv),
        .load_ready  (d1_ready),
        .sout        (d1_sout),
        .sout_valid  (d1_valid),
        .frame_start (d1_fs),
        .busy        (d1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic set_in(input int which, input logic v, input logic [7:0] d);
        if (which == 0) begin
            d0_lv  = v;
            d0_din = d;
        end else begin
            d1_lv  = v;
            d1_din = d;
        end
    endtask

    function automatic logic ready_of(input int which);
        return (which == 0) ? d0_ready : d1_ready;
    endfunction

    // Expected bits are given in transmit order: bits[7] goes out first.
    task automatic push_frame(input int which, input logic [7:0] bits, input logic par);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.sout = bits[7-i];
            e.fs   = (i == 0);
`ifdef MY_SERIALIZER_PARITY_EN
            e.rdy  = 1'b0;
`else
            e.rdy  = (i == 7);
`endif
            if (which == 0) q0.push_back(e); else q1.push_back(e);
        end
`ifdef MY_SERIALIZER_PARITY_EN
        e.sout = par;
        e.fs   = 1'b0;
        e.rdy  = 1'b1;
        if (which == 0) q0.push_back(e); else q1.push_back(e);
`endif
    endtask

    // Offers a word and returns just after the accepting edge with load_valid
    // still high, so a following send forms a back-to-back frame.
    task automatic send(input int which, input logic [7:0] word,
                        input logic [7:0] bits, input logic par);
        bit ok;
        ok = 1'b0;
        set_in(which, 1'b1, word);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ready_of(which)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk($sformatf("d%0d_accept_timeout", which), 8'd0, 8'd1);
        end else begin
            @(posedge clk);
            #1;
            push_frame(which, bits, par);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (q0.size() == 0 && q1.size() == 0) break;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("d0_drain_left", 8'(q0.size()), 8'd0);
        chk("d1_drain_left", 8'(q1.size()), 8'd0);
    endtask

    task automatic beat(input int which, input logic s, input logic v,
                        input logic fs, input logic rdy, input logic bsy);
        exp_t e;
        string p;
        p = $sformatf("d%0d_", which);
        if (v) begin
            if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
                chk({p, "unexpected_bit"}, 8'd1, 8'd0);
            end else begin
                if (which == 0) e = q0.pop_front(); else e = q1.pop_front();
                chk({p, "sout"},        8'(s),   8'(e.sout));
                chk({p, "frame_start"}, 8'(fs),  8'(e.fs));
                chk({p, "load_ready"},  8'(rdy), 8'(e.rdy));
                chk({p, "busy"},        8'(bsy), 8'd1);
            end
        end else begin
            chk({p, "idle_sout"},  8'(s),   8'd0);
            chk({p, "idle_busy"},  8'(bsy), 8'd0);
            chk({p, "idle_ready"}, 8'(rdy), 8'd1);
            chk({p, "idle_fs"},    8'(fs),  8'd0);
        end
    endtask

    always @(negedge clk) begin
        beat(0, d0_sout, d0_valid, d0_fs, d0_ready, d0_busy);
        beat(1, d1_sout, d1_valid, d1_fs, d1_ready, d1_busy);
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b0;
        d0_lv  = 1'b0;
        d1_lv  = 1'b0;
        d0_din = 8'h00;
        d1_din = 8'h00;
        #1 reset = 1'b1;
        #1;
        chk("rst_sout",  8'(d0_sout),  8'd0);
        chk("rst_valid", 8'(d0_valid), 8'd0);
        chk("rst_busy",  8'(d0_busy),  8'd0);
        chk("rst_ready", 8'(d0_ready), 8'd1);
        chk("rst_fs",    8'(d1_fs),    8'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // MSB first, single frame
        send(0, 8'hA5, 8'b10100101, 1'b0);
        set_in(0, 1'b0, 8'h00);
        drain();

        // LSB first: A5 then 01
        send(1, 8'hA5, 8'b10100101, 1'b0);
        set_in(1, 1'b0, 8'h00);
        send(1, 8'h01, 8'b10000000, 1'b1);
        set_in(1, 1'b0, 8'h00);
        drain();

        // Back-to-back with load_valid held high
        send(0, 8'hF0, 8'b11110000, 1'b0);
        send(0, 8'h0F, 8'b00001111, 1'b0);
        set_in(0, 1'b0, 8'h00);
        drain();

        // load_valid pulsed while not ready must be ignored
        send(0, 8'hA5, 8'b10100101, 1'b0);
        set_in(0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1 set_in(0, 1'b1, 8'h3C);
        @(posedge clk);
        #1 set_in(0, 1'b0, 8'h00);
        drain();

        // Parity words (plain frames in the default build)
        send(0, 8'h07, 8'b00000111, 1'b1);
        set_in(0, 1'b0, 8'h00);
        drain();
        send(0, 8'hA5, 8'b10100101, 1'b0);
        set_in(0, 1'b0, 8'h00);
        drain();

        // Reset in the middle of a frame
        send(0, 8'hA5, 8'b10100101, 1'b0);
        set_in(0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        q0.delete();
        #1;
        chk("midrst_sout",  8'(d0_sout),  8'd0);
        chk("midrst_valid", 8'(d0_valid), 8'd0);
        chk("midrst_busy",  8'(d0_busy),  8'd0);
        chk("midrst_ready", 8'(d0_ready), 8'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("postrst_busy", 8'(d0_busy), 8'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
